mips_instr_encoder: RTL

Sequential instruction encoder and program loader for the pipelined MIPS core. It accepts symbolic instruction fields over a valid/ready stream and packs them into 32-bit machine words using the exact opcode/funct map the control unit decodes. It then writes the words into instruction memory at consecutive addresses. It sits between the testbench/boot loader and the instruction-memory write port, and is used to load the sort, factorial and array-max programs before the core is released.

---
 rtl/mips_isa_pkg.sv | 61 ++++++
 rtl/mips_instr_pack.sv | 77 +++++++
 rtl/mips_instr_encoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - shared MIPS ISA constants, instruction ids and encoder state type
//
// Purpose: one source for the opcode/funct map. It is used by the instruction
// encoder and by the control unit. It also holds the symbolic instruction-id
// enumeration carried on in_op, and the encoder FSM state type.
// Ports: none (package).
package mips_isa_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_MUL = 6'b101100;

    // Symbolic instruction ids on in_op. Values 18..31 are illegal.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLT  = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_MUL  = 5'd8,
        OP_ADDI = 5'd9,
        OP_ANDI = 5'd10,
        OP_ORI  = 5'd11,
        OP_SLTI = 5'd12,
        OP_LW   = 5'd13,
        OP_SW   = 5'd14,
        OP_BEQ  = 5'd15,
        OP_BNE  = 5'd16,
        OP_J    = 5'd17
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mips_instr_pack.sv
// rtl/mips_instr_pack.sv - combinational packer from symbolic fields to a 32-bit MIPS word
//
// Purpose: map an instruction id plus its register, shift, immediate and target
// fields onto the machine encoding. Flag ids that have no encoding as illegal.
// Ports:
//   op      in  5   instruction id (mips_isa_pkg::op_e values)
//   rs..shamt in 5  register / shift-amount fields
//   imm     in  16  immediate or branch offset
//   target  in  26  jump target
//   word    out 32  encoded instruction (0 when illegal)
//   illegal out 1   op has no encoding
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic       is_r;
    logic       is_shift;
    logic       is_i;
    logic       is_j;
    logic [5:0] funct;
    logic [5:0] opc;

    always_comb begin
        is_r     = 1'b0;
        is_shift = 1'b0;
        is_i     = 1'b0;
        is_j     = 1'b0;
        funct    = 6'b000000;
        opc      = OPC_RTYPE;
        illegal  = 1'b0;
        case (op)
            OP_ADD:  begin is_r = 1'b1; funct = FUNCT_ADD; end
            OP_SUB:  begin is_r = 1'b1; funct = FUNCT_SUB; end
            OP_AND:  begin is_r = 1'b1; funct = FUNCT_AND; end
            OP_OR:   begin is_r = 1'b1; funct = FUNCT_OR;  end
            OP_SLT:  begin is_r = 1'b1; funct = FUNCT_SLT; end
            OP_XOR:  begin is_r = 1'b1; funct = FUNCT_XOR; end
            OP_SLL:  begin is_r = 1'b1; is_shift = 1'b1; funct = FUNCT_SLL; end
            OP_SRL:  begin is_r = 1'b1; is_shift = 1'b1; funct = FUNCT_SRL; end
            OP_MUL:  begin is_r = 1'b1; funct = FUNCT_MUL; end
            OP_ADDI: begin is_i = 1'b1; opc = OPC_ADDI; end
            OP_ANDI: begin is_i = 1'b1; opc = OPC_ANDI; end
            OP_ORI:  begin is_i = 1'b1; opc = OPC_ORI;  end
            OP_SLTI: begin is_i = 1'b1; opc = OPC_SLTI; end
            OP_LW:   begin is_i = 1'b1; opc = OPC_LW;   end
            OP_SW:   begin is_i = 1'b1; opc = OPC_SW;   end
            OP_BEQ:  begin is_i = 1'b1; opc = OPC_BEQ;  end
            OP_BNE:  begin is_i = 1'b1; opc = OPC_BNE;  end
            OP_J:    begin is_j = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    // Shifts take their operand from rt, so rs is zeroed. All other R ops zero shamt.
    always_comb begin
        word = 32'h0000_0000;
        if (is_r) begin
            word = {OPC_RTYPE, (is_shift ? 5'd0 : rs), rt, rd,
                    (is_shift ? shamt : 5'd0), funct};
        end else if (is_i) begin
            word = {opc, rs, rt, imm};
        end else if (is_j) begin
            word = {OPC_J, target};
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - streaming instruction encoder and instruction-memory loader
//
// Purpose: accept symbolic instruction fields over a valid/ready stream. Encode
// each one and write the words to consecutive instruction-memory addresses,
// starting at base_addr. A single output register holds the pending write.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr      begin a session at base_addr (IDLE only)
//   in_valid/in_ready     field handshake; in_op, in_rs, in_rt, in_rd, in_shamt,
//                         in_imm, in_target are the fields; in_last ends the program
//   imem_we/imem_addr/imem_wdata/imem_ready   memory write port
//   busy, done, err, word_count              session status
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    // Set once the write at ADDR_MAX has completed. The address then stays pinned.
    logic              ovf_q, ovf_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept;
    logic        drain;
    logic        at_max;

    mips_instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH: if (!we_q || imem_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == ST_LOAD) && (!we_q || imem_ready);
        busy     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
        done     = (state_q == ST_DONE);
    end

    assign accept = in_valid && in_ready;
    assign drain  = we_q && imem_ready;
    assign at_max = (addr_q == ADDR_MAX);

    // Address, counter and output register. A drain and an accept in the same
    // cycle replace the word with no bubble. The new word goes to the advanced address.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                addr_d  = base_addr;
                count_d = '0;
                err_d   = 1'b0;
                ovf_d   = 1'b0;
                we_d    = 1'b0;
            end
        end else begin
            if (drain) begin
                we_d    = 1'b0;
                count_d = count_q + CNT_ONE;
                if (at_max) ovf_d  = 1'b1;
                else        addr_d = addr_q + ADDR_ONE;
            end
            if (accept) begin
                // Drop the word if it is illegal or if no address remains after ADDR_MAX.
                if (pack_illegal || ovf_q || (drain && at_max)) begin
                    err_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = pack_word;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign word_count = count_q;

endmodule
